// File: rtl/otn_frame_tx.sv
// Transmit-side OTN framer: 4x1041 byte frame with FAS/MFAS overhead and pulled payload.
// Optional BIP-8 over the previous frame's payload at row 0 col 7: define OTN_FRAME_TX_BIP8_EN.
module otn_frame_tx #(
  parameter int unsigned OH_COLS  = 16,
  parameter int unsigned LAST_COL = 1040
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_data_req,
  input  logic        i_pl_valid,
  input  logic [7:0]  i_pl_data,
  output logic        o_pl_req,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_underrun,
  output logic        o_busy
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;
  localparam logic [10:0] OhCol   = 11'(OH_COLS);
  localparam logic [10:0] LastCol = 11'(LAST_COL);

  logic [0:0]  state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [10:0] col_q, col_d;
  logic [7:0]  mfas_q, mfas_d;

  logic        send, is_pay, last_byte;
  logic [7:0]  byte_mux, bip_byte;

  logic        valid_q, valid_d, sof_q, sof_d, und_q, und_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  orow_q, orow_d;
  logic [10:0] ocol_q, ocol_d;

  assign send      = (state_q == ST_RUN) && i_data_req;
  assign is_pay    = col_q >= OhCol;
  assign last_byte = (row_q == 2'd3) && (col_q == LastCol);
  assign o_pl_req  = send && is_pay;
  assign o_busy    = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mfas_d  = mfas_q;
    case (state_q)
      ST_IDLE: begin
        row_d = 2'd0;
        col_d = 11'd0;
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (send) begin
          if (col_q == LastCol) begin
            col_d = 11'd0;
            row_d = row_q + 2'd1;
            // Enable is only honoured at the frame boundary so frames are never cut short.
            if (row_q == 2'd3) begin
              mfas_d  = mfas_q + 8'd1;
              state_d = i_enable ? ST_RUN : ST_IDLE;
            end
          end else begin
            col_d = col_q + 11'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_mux = 8'h00;
    if (is_pay) begin
      byte_mux = i_pl_valid ? i_pl_data : 8'h00;
    end else if (row_q == 2'd0) begin
      if (col_q < 11'd3)       byte_mux = 8'hF6;
      else if (col_q < 11'd6)  byte_mux = 8'h28;
      else if (col_q == 11'd6) byte_mux = mfas_q;
      else if (col_q == 11'd7) byte_mux = bip_byte;
    end
  end

`ifdef OTN_FRAME_TX_BIP8_EN
  logic [7:0] acc_q, acc_d, bip_q, bip_d;

  always_comb begin
    acc_d = acc_q;
    bip_d = bip_q;
    if (send && is_pay) acc_d = acc_q ^ byte_mux;
    if (send && last_byte) begin
      bip_d = acc_d;
      acc_d = 8'h00;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= 8'h00;
      bip_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
      bip_q <= bip_d;
    end
  end

  assign bip_byte = bip_q;
`else
  assign bip_byte = 8'h00;
`endif

  always_comb begin
    valid_d = send;
    sof_d   = send && (row_q == 2'd0) && (col_q == 11'd0);
    und_d   = o_pl_req && !i_pl_valid;
    data_d  = send ? byte_mux : data_q;
    orow_d  = send ? row_q : orow_q;
    ocol_d  = send ? col_q : ocol_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= 2'd0;
      col_q   <= 11'd0;
      mfas_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      und_q   <= 1'b0;
      data_q  <= 8'h00;
      orow_q  <= 2'd0;
      ocol_q  <= 11'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mfas_q  <= mfas_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      und_q   <= und_d;
      data_q  <= data_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_sof      = sof_q;
  assign o_row_cnt  = orow_q;
  assign o_col_cnt  = ocol_q;
  assign o_underrun = und_q;

endmodule

// File: tb/tb_otn_frame_tx.sv
// Randomized bench for otn_frame_tx against a byte-index frame model.
// Honours OTN_FRAME_TX_BIP8_EN the same way as the design build.
module tb_otn_frame_tx;

  localparam int FrameBytes = 4 * 1041;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, data_req = 1'b0, pl_valid = 1'b0;
  logic [7:0]  pl_data = 8'h00;
  logic        pl_req, valid, sof, underrun, busy;
  logic [7:0]  data;
  logic [1:0]  row_cnt;
  logic [10:0] col_cnt;

  otn_frame_tx dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_data_req (data_req),
    .i_pl_valid (pl_valid),
    .i_pl_data  (pl_data),
    .o_pl_req   (pl_req),
    .o_valid    (valid),
    .o_data     (data),
    .o_sof      (sof),
    .o_row_cnt  (row_cnt),
    .o_col_cnt  (col_cnt),
    .o_underrun (underrun),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: running flag, byte index within frame, frames since reset, BIP bookkeeping.
  bit   run_m = 0;
  int   idx = 0;
  int   frames = 0;
  bit [7:0] acc_m = 0, bip_m = 0;
  bit   e_valid = 0, e_sof = 0, e_und = 0;
  bit [7:0]  e_data = 0;
  bit [1:0]  e_row = 0;
  bit [10:0] e_col = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (frame %0d idx %0d t=%0t)",
               tag, got, exp, frames, idx, $time);
    end
  endtask

  function automatic bit [7:0] frame_byte(int r, int c, bit plv, bit [7:0] pld);
    if (c >= 16) return plv ? pld : 8'h00;
    if (r != 0)  return 8'h00;
    if (c < 3)   return 8'hF6;
    if (c < 6)   return 8'h28;
    if (c == 6)  return 8'(frames % 256);
`ifdef OTN_FRAME_TX_BIP8_EN
    if (c == 7)  return bip_m;
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    run_m = 0; idx = 0; frames = 0; acc_m = 0; bip_m = 0;
    e_valid = 0; e_sof = 0; e_und = 0; e_data = 0; e_row = 0; e_col = 0;
  endtask

  task automatic cycle(input bit en, input int req_pct, input int plv_pct);
    int r, c;
    bit snd, pay;
    bit [7:0] b;
    @(negedge clk);
    chk("valid", valid, e_valid);
    if (e_valid) begin
      chk("data", data, e_data);
      chk("row", row_cnt, e_row);
      chk("col", col_cnt, e_col);
    end
    chk("sof", sof, e_sof);
    chk("underrun", underrun, e_und);
    chk("busy", busy, run_m);
    enable   = en;
    data_req = ($urandom_range(99) < req_pct);
    pl_valid = ($urandom_range(99) < plv_pct);
    pl_data  = 8'($urandom);
    #1;
    snd = run_m && data_req;
    r   = idx / 1041;
    c   = idx % 1041;
    pay = (c >= 16);
    chk("pl_req", pl_req, snd && pay);
    if (snd) begin
      b = frame_byte(r, c, pl_valid, pl_data);
      e_valid = 1; e_data = b; e_row = 2'(r); e_col = 11'(c);
      e_sof = (idx == 0); e_und = pay && !pl_valid;
      if (pay) acc_m ^= b;
      idx++;
      if (idx == FrameBytes) begin
        idx = 0; frames++; bip_m = acc_m; acc_m = 0; run_m = en;
      end
    end else begin
      e_valid = 0; e_sof = 0; e_und = 0;
      if (!run_m) run_m = en;
    end
  endtask

  task automatic run_to_frames(input int target, input int req_pct, input int plv_pct);
    int n = 0;
    while (frames < target && n < 20000) begin
      cycle(1'b1, req_pct, plv_pct);
      n++;
    end
    if (frames < target) chk("frame_timeout", frames, target);
  endtask

  task automatic run_to_idx(input int target, input int req_pct);
    int n = 0;
    while (idx < target && n < 10000) begin
      cycle(1'b1, req_pct, 95);
      n++;
    end
    if (idx < target) chk("idx_timeout", idx, target);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, 100, 100);

    // Back-to-back request with full payload supply, then randomized gaps and underruns.
    run_to_frames(1, 100, 100);
    run_to_frames(3, 70, 90);

    // Enable dropped mid-frame: frame must complete, then the framer idles.
    run_to_idx(2 * 1041 + 500, 80);
    begin
      int n = 0;
      while (run_m && n < 10000) begin
        cycle(1'b0, 80, 95);
        n++;
      end
      if (run_m) chk("drain_timeout", 0, 1);
    end
    repeat (20) cycle(1'b0, 100, 100);

    // Re-enable, then reset in the middle of row 1.
    run_to_idx(1041 + 300, 90);
    @(negedge clk);
    enable = 1'b0; data_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_sof", sof, 0);
    chk("rst_row", row_cnt, 0);
    chk("rst_col", col_cnt, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pl_req", pl_req, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 100, 100);

    // Post-reset frames restart at (0,0) with mfas 0 and a cleared BIP.
    run_to_frames(2, 75, 85);
    repeat (10) cycle(1'b0, 100, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/otn_frame_tx.md
Name: otn_frame_tx

Overview:
- Transmit-side framer. Builds the 4-row x 1041-column byte frame (rows 0..3, columns 0..1040) that the receive-side frame position counter tracks.
- Inserts overhead: FAS, multiframe counter and a reserved byte. Pulls payload bytes from an upstream source. Emits one byte per cycle when the downstream link requests data.
- Position outputs use the same row/column encoding as the receive counter, so the two ends can be compared directly.

Parameters:
- OH_COLS, 16, number of overhead columns per row (columns 0..OH_COLS-1); payload occupies columns OH_COLS..1040.
- LAST_COL, 1040, final column index; column wraps to 0 after it.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  framer enable; sampled only at idle and at frame boundaries
- i_data_req  in  1  downstream requests one byte this cycle
- i_pl_valid  in  1  upstream payload byte valid (same-cycle response to o_pl_req)
- i_pl_data  in  8  upstream payload byte
- o_pl_req  out  1  combinational; payload byte consumed this cycle
- o_valid  out  1  o_data valid
- o_data  out  8  frame byte
- o_sof  out  1  o_data is row 0 column 0
- o_row_cnt  out  2  row of byte on o_data
- o_col_cnt  out  11  column of byte on o_data
- o_underrun  out  1  one-cycle pulse: payload column filled with 0x00 because i_pl_valid was 0
- o_busy  out  1  state is RUN

Behaviour:
- Reset: one clock (i_clk); reset is asynchronous and active-low (i_rst_n).
- On reset assertion, all outputs go to 0 immediately, state goes to IDLE, internal row/col go to 0, and mfas (8-bit) goes to 0.
- States:
  - IDLE: o_busy=0. Goes to RUN when i_enable=1. Internal position is forced to (0,0).
  - RUN: o_busy=1.
- send = (state==RUN) && i_data_req.
- Position counter (next byte to emit) advances only on send:
  - col++ each send.
  - col==LAST_COL: col<=0, row++.
  - row 3, col LAST_COL: row<=0, col<=0, mfas<=mfas+1 (mod 256).
  - Last-byte send: next state = i_enable ? RUN : IDLE. RUN stays RUN mid-frame even if i_enable drops, so frames are never truncated.
- Byte mux, selected by current position:
  - Row 0, cols 0-2: 0xF6.
  - Row 0, cols 3-5: 0x28.
  - Row 0, col 6: mfas.
  - Row 0, col 7: see Optional Feature.
  - Any other column < OH_COLS: 0x00.
  - Column >= OH_COLS: i_pl_valid ? i_pl_data : 0x00.
- o_pl_req = send && col >= OH_COLS, combinational, no register. Upstream must present data in the same cycle.
- Output register, latency 1 cycle from the send cycle:
  - On send: o_valid<=1, o_data<=mux, o_row_cnt<=row, o_col_cnt<=col, o_sof<=(row==0 && col==0), o_underrun<=(o_pl_req && !i_pl_valid).
  - No send: o_valid<=0, o_sof<=0, o_underrun<=0. o_data, o_row_cnt and o_col_cnt hold.
- i_data_req gaps: position frozen, no bytes skipped, mfas unaffected.
- i_pl_valid while o_pl_req=0: ignored.
- i_enable toggling mid-frame: no effect until the frame boundary.
- Reset mid-frame: the frame is abandoned. After release, the next frame starts at (0,0) with mfas=0.

Optional Feature:
- Macro OTN_FRAME_TX_BIP8_EN.
- Defined:
  - An 8-bit accumulator XORs every payload byte emitted in frame N (including 0x00 underrun fills).
  - The accumulated value is latched at frame end and emitted at row 0 col 7 of frame N+1.
  - The accumulator clears to 0 at the start of each frame.
  - The first frame after reset carries 0x00.
  - Reset clears both the accumulator and the latched value.
- Undefined: row 0 col 7 is constant 0x00 and no accumulator logic exists.

Test Plan:
- Reset release, i_enable=1, i_data_req=1, i_pl_valid=1, i_pl_data=col[7:0] -> first o_valid is 1 cycle after the first send. Bytes F6 F6 F6 28 28 28 00 00..., o_sof=1 only on (0,0). 4164 bytes per frame; (3,1040) is followed by (0,0).
- Two consecutive frames -> col 6 of row 0 is 0x00 then 0x01. After 256 frames mfas wraps to 0x00.
- i_data_req toggled 1/0 every cycle -> o_valid follows with 1-cycle delay. Position sequence is contiguous, no repeats or skips. o_pl_req is never high while i_data_req=0.
- i_pl_valid=0 at row 1 col 20 -> o_data=0x00 at (1,20), o_underrun pulses exactly once, position continues to (1,21).
- i_enable dropped at row 2 col 500 -> frame completes through (3,1040), o_busy falls the next cycle, no further o_valid. Re-enable -> frame restarts at (0,0).
- i_rst_n asserted at row 1 col 300 -> outputs 0 asynchronously. After release, emission resumes at (0,0) with mfas=0x00. With BIP8_EN: all payload bytes=0x01 -> next frame col 7 = XOR of 4100 ones = 0x00; payload 0x01 with one underrun -> 0x01.
